score_packer: RTL and testbench
===============================

Name: score_packer

Overview:
- Sits between the final fully-connected layer and the combinational argmax stage.
- Accepts one output-neuron accumulator per valid/ready beat, in neuron order 0..N_CLASSES-1.
- Requantizes each accumulator to an unsigned 8-bit score and packs it into the flat score vector the argmax stage consumes.
- Holds the complete vector under a valid/ready handshake until the consumer takes it.

Parameters:
- N_CLASSES, 10, number of output neurons per frame.
- ACC_W, 20, width of the signed accumulator input.
- SCORE_W, 8, width of each packed unsigned score.
- SHIFT, 8, arithmetic right shift applied during requantization.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  accumulator beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_acc  input  ACC_W  signed accumulator of the current neuron.
- in_last  input  1  producer marks the final neuron of the frame.
- out_valid  output  1  packed vector complete and stable.
- out_ready  input  1  consumer takes the vector.
- out_vector  output  N_CLASSES*SCORE_W  neuron k occupies bits [k*SCORE_W+SCORE_W-1 : k*SCORE_W]; neuron 0 sits in the LSBs.
- frame_err  output  1  one-cycle pulse on a framing mismatch.

Behaviour:
- Reset values (rst_n=0): state COLLECT, idx=0, out_vector=0, out_valid=0, frame_err=0. in_ready reads 1 once reset is released.
- FSM has two states, COLLECT and HOLD.
- in_ready = (state==COLLECT). out_valid = (state==HOLD). Both are registered-state decodes with no combinational path from out_ready to in_ready.
- Beat accept: in_valid && in_ready.
- Requantization, applied to each accepted beat:
  - in_acc < 0 gives a score of 0.
  - Otherwise t = in_acc >> SHIFT, and score = min(t, 2^SCORE_W-1).
- Each accepted beat writes its score into slot idx on the next edge.
- COLLECT, accepted beat with idx < N_CLASSES-1 and in_last=0: write the slot, idx += 1.
- COLLECT, accepted beat with idx < N_CLASSES-1 and in_last=1 (short frame):
  - Discard the frame: slot contents are don't-care, idx=0, stay in COLLECT.
  - Pulse frame_err the following cycle.
  - out_valid stays 0.
- COLLECT, accepted beat with idx == N_CLASSES-1:
  - Write the slot, idx=0, go to HOLD. out_valid rises the next cycle.
  - If in_last=0 (long frame), still complete the frame and pulse frame_err once. The producer's surplus beats stall because in_ready=0.
- HOLD: out_vector stays frozen. When out_valid && out_ready, go to COLLECT on that edge.
  - in_ready returns high the cycle after the handshake.
  - Minimum frame period is N_CLASSES+1 cycles.
- Slots are not cleared between frames. Every slot is rewritten before the next HOLD.
- A beat with in_valid=0 never advances idx. Gaps between beats of any length are legal.
- An rst_n assert mid-frame or in HOLD aborts immediately to the reset values. No partial vector is ever presented.

Optional Feature:
- Macro: SCORE_PACKER_ARGMAX_EN.
- Defined:
  - Adds output out_class, width $clog2(N_CLASSES), with reset value 0.
  - A running max register and running index update on every accepted beat.
  - idx==0 loads unconditionally. Later beats replace the max only when the new score > max (strict), so ties resolve to the lowest index.
  - out_class is valid whenever out_valid=1 and equals the lowest index holding the maximum score.
  - A short-frame discard resets the trackers.
- Undefined: the out_class port and the tracking logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then ten beats with in_acc = k*256 (k=0..9), no gaps, in_last on the 10th.
   - Required: out_valid rises one cycle after the 10th accept, out_vector slot k = k, frame_err = 0.
   - With the macro defined: out_class = 9.
2. Saturation and sign: slot 0 gets -5, slot 1 gets 0x7FFFF, slot 2 gets 255, slots 3..9 get 512.
   - Required: scores 0, 255, 0, and 2 for slots 3..9.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid while the producer keeps in_valid=1.
   - Required: in_ready=0, out_vector stable, no extra beats accepted.
   - Release out_ready: in_ready=1 the next cycle, and the next frame fills from slot 0.
4. Short frame: in_last on the 4th beat.
   - Required: frame_err pulses one cycle, out_valid stays 0, and the following full 10-beat frame packs correctly.
   - Long frame: 10th beat with in_last=0; frame completes and frame_err pulses.
5. Reset mid-operation: assert rst_n=0 after 6 beats, release, then send a full frame.
   - Required: out_vector=0 during reset, out_valid=0, and only the new frame's scores are presented.
6. Macro defined, ties: scores 7,3,9,9,1,9,0,0,0,0.
   - Required: out_class = 2.
   - Random gaps in in_valid give the identical result.

Source files
------------

// File: rtl/score_packer.sv
// Collects one requantized 8-bit score per accepted accumulator beat and presents the
// packed frame to argmax. SCORE_PACKER_ARGMAX_EN adds running-argmax output out_class.

module score_packer_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (we) q <= d;
    end
endmodule

module score_packer #(
    parameter int N_CLASSES = 10,
    parameter int ACC_W     = 20,
    parameter int SCORE_W   = 8,
    parameter int SHIFT     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ACC_W-1:0]             in_acc,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_CLASSES*SCORE_W-1:0] out_vector,
    output logic                         frame_err
`ifdef SCORE_PACKER_ARGMAX_EN
   ,output logic [$clog2(N_CLASSES)-1:0] out_class
`endif
);
    localparam int IDX_W = $clog2(N_CLASSES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);
    localparam logic [ACC_W-1:0] SAT  = ACC_W'((1 << SCORE_W) - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                             state;
    logic [IDX_W-1:0]                   idx;
    logic [ACC_W-1:0]                   shifted;
    logic [SCORE_W-1:0]                 score;
    logic                               acc_fire;
    logic [N_CLASSES-1:0][SCORE_W-1:0]  slot_q;

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign acc_fire  = in_valid && in_ready;

    // Negative accumulators clamp to zero, large positives saturate.
    assign shifted = in_acc >> SHIFT;
    always_comb begin
        score = '0;
        if (!in_acc[ACC_W-1])
            score = (shifted > SAT) ? SAT[SCORE_W-1:0] : shifted[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (acc_fire) begin
                        if (idx == LAST) begin
                            // Long frames still complete; surplus beats stall on in_ready.
                            idx       <= '0;
                            state     <= HOLD;
                            frame_err <= !in_last;
                        end else if (in_last) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: if (out_ready) state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

    for (genvar k = 0; k < N_CLASSES; k++) begin : g_slot
        score_packer_slot #(.W(SCORE_W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (acc_fire && (idx == IDX_W'(k))),
            .d     (score),
            .q     (slot_q[k])
        );
    end

    assign out_vector = slot_q;

`ifdef SCORE_PACKER_ARGMAX_EN
    logic [SCORE_W-1:0] max_q;
    logic [IDX_W-1:0]   cls_q;

    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            cls_q <= '0;
        end else if (acc_fire) begin
            if (idx != LAST && in_last) begin
                max_q <= '0;
                cls_q <= '0;
            end else if (idx == '0 || score > max_q) begin
                max_q <= score;
                cls_q <= idx;
            end
        end
    end

    assign out_class = cls_q;
`endif
endmodule

// File: tb/tb_score_packer.sv
// Directed bench for score_packer: packing, saturation, backpressure, framing errors,
// mid-frame reset, and (with SCORE_PACKER_ARGMAX_EN) tie-breaking of out_class.

module tb_score_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [19:0] in_acc;
    logic        out_valid, out_ready;
    logic [79:0] out_vector;
    logic        frame_err;
`ifdef SCORE_PACKER_ARGMAX_EN
    logic [3:0]  out_class;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    logic        ov_pre;
    logic [19:0] acc_tab [10];

    always #5 clk = ~clk;

    score_packer #(.N_CLASSES(10), .ACC_W(20), .SCORE_W(8), .SHIFT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_acc     (in_acc),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .frame_err  (frame_err)
`ifdef SCORE_PACKER_ARGMAX_EN
       ,.out_class  (out_class)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [19:0] a, input logic l, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_acc = a; in_last = l;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 128'(in_ready), 128'd1);
        ov_pre = out_valid;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic frame(input int maxgap);
        for (int k = 0; k < 10; k++)
            send(acc_tab[k], k == 9, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_frame(input string tag, input logic [79:0] ev, input logic [3:0] ec,
                               input logic ferr);
        chk({tag, "_ov_pre"}, 128'(ov_pre), 128'd0);
        @(negedge clk);
        chk({tag, "_ov"},   128'(out_valid), 128'd1);
        chk({tag, "_vec"},  128'(out_vector), 128'(ev));
        chk({tag, "_ferr"}, 128'(frame_err), 128'(ferr));
`ifdef SCORE_PACKER_ARGMAX_EN
        chk({tag, "_cls"},  128'(out_class), 128'(ec));
`else
        if (ec > 4'd9) chk({tag, "_ec_range"}, 128'(ec), 128'd0);
`endif
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 128'(in_ready), 128'd1);
        chk({tag, "_ov_after"},  128'(out_valid), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_acc = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec",  128'(out_vector), 128'd0);
        chk("rst_ov",   128'(out_valid), 128'd0);
        chk("rst_ferr", 128'(frame_err), 128'd0);
`ifdef SCORE_PACKER_ARGMAX_EN
        chk("rst_cls",  128'(out_class), 128'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 128'(in_ready), 128'd1);

        // 1: ramp, slot k = k
        for (int k = 0; k < 10; k++) acc_tab[k] = 20'(k * 256);
        frame(0);
        check_frame("t1", 80'h09080706050403020100, 4'd9, 1'b0);
        take("t1");

        // 2: sign clamp and saturation
        acc_tab[0] = -20'sd5; acc_tab[1] = 20'h7FFFF; acc_tab[2] = 20'd255;
        for (int k = 3; k < 10; k++) acc_tab[k] = 20'd512;
        frame(0);
        check_frame("t2", 80'h0202020202020200FF00, 4'd1, 1'b0);

        // 3: backpressure with producer pushing
        @(negedge clk);
        in_valid = 1'b1; in_acc = 20'h01000; in_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_rdy_hold", 128'(in_ready), 128'd0);
            chk("t3_vec_hold", 128'(out_vector), 128'h0202020202020200FF00);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("t3_rdy_release", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k < 10; k++) send(20'((8'h30 + k) * 256), k == 9, 0);
        check_frame("t3", 80'h39383736353433323110, 4'd9, 1'b0);
        take("t3");

        // 4a: short frame
        for (int k = 0; k < 4; k++) send(20'h7FFFF, k == 3, 0);
        @(negedge clk);
        chk("t4_short_ferr", 128'(frame_err), 128'd1);
        chk("t4_short_ov",   128'(out_valid), 128'd0);
        @(negedge clk);
        chk("t4_short_ferr_end", 128'(frame_err), 128'd0);
        chk("t4_short_ov_end",   128'(out_valid), 128'd0);
        for (int k = 0; k < 10; k++) acc_tab[k] = 20'(k * 256);
        frame(0);
        check_frame("t4_after", 80'h09080706050403020100, 4'd9, 1'b0);
        take("t4_after");

        // 4b: long frame, tenth beat lacks in_last
        for (int k = 0; k < 10; k++) send(20'((9 - k) * 256), 1'b0, 0);
        check_frame("t4_long", 80'h00010203040506070809, 4'd0, 1'b1);
        @(negedge clk);
        chk("t4_long_ferr_end", 128'(frame_err), 128'd0);
        take("t4_long");

        // 5: reset mid-frame
        for (int k = 0; k < 6; k++) send(20'h7FFFF, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vec", 128'(out_vector), 128'd0);
        chk("t5_rst_ov",  128'(out_valid), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_tab[0] = -20'sd5; acc_tab[1] = 20'h7FFFF; acc_tab[2] = 20'd255;
        for (int k = 3; k < 10; k++) acc_tab[k] = 20'd512;
        frame(0);
        check_frame("t5", 80'h0202020202020200FF00, 4'd1, 1'b0);
        take("t5");

        // 6: ties resolve to lowest index, with and without gaps
        acc_tab[0] = 20'(7 * 256); acc_tab[1] = 20'(3 * 256); acc_tab[2] = 20'(9 * 256);
        acc_tab[3] = 20'(9 * 256); acc_tab[4] = 20'(1 * 256); acc_tab[5] = 20'(9 * 256);
        for (int k = 6; k < 10; k++) acc_tab[k] = 20'd0;
        frame(0);
        check_frame("t6", 80'h00000000090109090307, 4'd2, 1'b0);
        take("t6");
        frame(3);
        check_frame("t6_gaps", 80'h00000000090109090307, 4'd2, 1'b0);
        take("t6_gaps");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
